// File: rtl/fe_power_seq.sv
// ---------------------------------------------------------------------------
// fe_power_seq -- front-end power / reset sequencer.
//
// Holds every front-end enable (tuner i2c gate, CI power, antenna 5 V,
// demod/tuner resets) at its safe level through a power-on hold. After that
// it releases requested channels one at a time, lowest index first, with a
// programmable stagger between releases. A channel whose ctrl bit goes high
// is re-asserted on the very next edge in every state. USB suspend drives
// all pins safe. When suspend ends, the block waits one settle gap and then
// re-sequences.
//
// Ports
//   clk       system clock (usb_ulpi_clk domain)
//   reset     synchronous, active-high
//   suspend   USB suspend, synchronous to clk
//   ctrl      per-channel request: 1 = held (disabled), 0 = released
//   fe_out    registered pin levels (SAFE_VAL while held)
//   released  per-channel status: 1 = channel currently released
//   por_done  high once the power-on hold has expired, until reset
//   busy      high when not IDLE or any channel is still pending release
// ---------------------------------------------------------------------------

// One pin driver. The pin is registered from the next-cycle released bit, so
// fe_out and released change on the same edge.
module fe_power_lane #(
  parameter logic SAFE_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic rel_nxt,
  output logic pin
);
  always_ff @(posedge clk) begin
    if (reset) pin <= SAFE_BIT;
    else       pin <= rel_nxt ? ~SAFE_BIT : SAFE_BIT;
  end
endmodule

module fe_power_seq #(
  parameter int              N_CH       = 8,
  parameter logic [N_CH-1:0] SAFE_VAL   = 8'h60,
  parameter int              CLK_PER_US = 50,
  parameter int              POR_US     = 1000000,
  parameter int              STAGGER_US = 1000,
  parameter int              CNT_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            suspend,
  input  logic [N_CH-1:0] ctrl,
  output logic [N_CH-1:0] fe_out,
  output logic [N_CH-1:0] released,
  output logic            por_done,
  output logic            busy
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [1:0] {S_POR, S_IDLE, S_GAP, S_SUSP} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     presc;
  logic [CNT_W-1:0]  cnt;
  logic              tick, expire, ld_gap;
  logic [N_CH-1:0]   pending, assert_req, lowest, rel_nxt;

  assign pending    = ~ctrl & ~released;
  assign assert_req =  ctrl &  released;
  // Isolate the lowest set bit of pending. Only that channel may be
  // released on this IDLE visit.
  assign lowest     = pending & (~pending + N_CH'(1));

  // The tick fires on the last prescaler count. Expiry is the tick that
  // would take the counter from 1 to 0.
  assign tick   = (presc == PW'(CLK_PER_US - 1));
  assign expire = tick && (cnt == CNT_W'(1));

  assign busy = (state != S_IDLE) || (|pending);

  // Next state and next released vector. The assertion path
  // (released & ~assert_req) applies in every state and never touches the
  // timer, so a mid-GAP assert leaves the stagger schedule intact.
  always_comb begin
    state_nxt = state;
    rel_nxt   = released & ~assert_req;
    ld_gap    = 1'b0;
    case (state)
      S_POR: begin
        rel_nxt = '0;
        if (expire) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (suspend) begin
          // Suspend wins over a pending release in the same cycle.
          state_nxt = S_SUSP;
          rel_nxt   = '0;
        end else if (|pending) begin
          rel_nxt = rel_nxt | lowest;
          if (STAGGER_US != 0) begin
            state_nxt = S_GAP;
            ld_gap    = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (suspend) begin
          state_nxt = S_SUSP;
          rel_nxt   = '0;
        end else if (expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_SUSP: begin
        rel_nxt = '0;
        if (!suspend) begin
          // Settle for one stagger period before re-sequencing.
          if (STAGGER_US != 0) begin
            state_nxt = S_GAP;
            ld_gap    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_POR;
        rel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_POR;
      presc    <= '0;
      cnt      <= CNT_W'(POR_US);
      released <= '0;
      por_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      released <= rel_nxt;
      if (state == S_POR && expire) por_done <= 1'b1;
      if (ld_gap) begin
        presc <= '0;
        cnt   <= CNT_W'(STAGGER_US);
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && (state == S_POR || state == S_GAP)) cnt <= cnt - 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    fe_power_lane #(.SAFE_BIT(SAFE_VAL[gi])) u_lane (
      .clk     (clk),
      .reset   (reset),
      .rel_nxt (rel_nxt[gi]),
      .pin     (fe_out[gi])
    );
  end

endmodule

// File: tb/tb_fe_power_seq.sv
module tb_fe_power_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       suspend = 1'b0;
  logic [7:0] ctrl = 8'hFF;
  logic [7:0] fe_out, released;
  logic       por_done, busy;

  // Second instance with zero stagger.
  logic       suspend_b = 1'b0;
  logic [7:0] ctrl_b = 8'hFF;
  logic [7:0] fe_out_b, released_b;
  logic       por_done_b, busy_b;

  int ecnt = 0;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Edge counter: edge 1 is the first edge that samples reset low.
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  fe_power_seq #(.N_CH(8), .SAFE_VAL(8'h60), .CLK_PER_US(2), .POR_US(5),
                 .STAGGER_US(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .suspend(suspend), .ctrl(ctrl),
    .fe_out(fe_out), .released(released), .por_done(por_done), .busy(busy));

  fe_power_seq #(.N_CH(8), .SAFE_VAL(8'h60), .CLK_PER_US(2), .POR_US(5),
                 .STAGGER_US(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .suspend(suspend_b), .ctrl(ctrl_b),
    .fe_out(fe_out_b), .released(released_b), .por_done(por_done_b), .busy(busy_b));

  typedef struct {
    int         e;
    logic [7:0] ctrl;
    logic       sus;
    logic [7:0] rel;
    logic       por;
    logic       busy;
  } vec_t;

  typedef struct {
    int         e;
    logic [7:0] rel;
    logic       por;
    logic       busy;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Return just after the negedge that follows edge n.
  task automatic at_edge(input int n);
    while (ecnt < n) @(negedge clk);
    #1;
  endtask

  task automatic add(input int e, input logic [7:0] c, input logic s,
                     input logic [7:0] r, input logic p, input logic b);
    vec_t v;
    v.e = e; v.ctrl = c; v.sus = s; v.rel = r; v.por = p; v.busy = b;
    vt.push_back(v);
  endtask

  task automatic expect_at(input int e, input logic [7:0] r, input logic p, input logic b);
    exp_t x;
    x.e = e; x.rel = r; x.por = p; x.busy = b;
    sb.push_back(x);
  endtask

  // Scoreboard: compare dut outputs after the edge each expectation names.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e == ecnt) begin
      exp_t x;
      x = sb.pop_front();
      chk($sformatf("e%0d released", x.e), released, x.rel);
      chk($sformatf("e%0d fe_out", x.e), fe_out, x.rel ^ 8'h60);
      chk($sformatf("e%0d por_done", x.e), por_done, x.por);
      chk($sformatf("e%0d busy", x.e), busy, x.busy);
    end
  end

  // Watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: sim time exceeded, ecnt=%0d", ecnt);
    $fatal(1);
  end

  // Main instance: POR, stagger, immediate assert, suspend, mid-GAP reset.
  initial begin
    // Vector = inputs seen at edge e, outputs expected after edge e.
    add( 1, 8'hFF, 0, 8'h00, 0, 1);
    add( 9, 8'hFF, 0, 8'h00, 0, 1);
    add(10, 8'hFF, 0, 8'h00, 1, 0);
    add(11, 8'h00, 0, 8'h01, 1, 1);
    add(17, 8'h00, 0, 8'h01, 1, 1);
    add(18, 8'h00, 0, 8'h03, 1, 1);
    add(24, 8'h00, 0, 8'h03, 1, 1);
    add(25, 8'h00, 0, 8'h07, 1, 1);
    add(28, 8'h02, 0, 8'h05, 1, 1);  // assert ch1 mid-GAP
    add(31, 8'h02, 0, 8'h05, 1, 1);
    add(32, 8'h02, 0, 8'h0D, 1, 1);  // ch3 on schedule
    add(33, 8'hF0, 0, 8'h0D, 1, 1);
    add(38, 8'hF0, 0, 8'h0D, 1, 1);
    add(39, 8'hF0, 0, 8'h0F, 1, 1);
    add(44, 8'hF0, 0, 8'h0F, 1, 1);
    add(45, 8'hF0, 0, 8'h0F, 1, 0);
    add(46, 8'hF0, 0, 8'h0F, 1, 0);
    add(47, 8'hF0, 1, 8'h00, 1, 1);  // suspend edges 47..50
    add(50, 8'hF0, 1, 8'h00, 1, 1);
    add(51, 8'hF0, 0, 8'h00, 1, 1);  // settle GAP
    add(57, 8'hF0, 0, 8'h00, 1, 1);
    add(58, 8'hF0, 0, 8'h01, 1, 1);
    add(64, 8'hF0, 0, 8'h01, 1, 1);
    add(65, 8'hF0, 0, 8'h03, 1, 1);
    add(72, 8'hF0, 0, 8'h07, 1, 1);
    add(79, 8'hF0, 0, 8'h0F, 1, 1);
    add(84, 8'hF0, 0, 8'h0F, 1, 1);
    add(85, 8'hF0, 0, 8'h0F, 1, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst released", released, 8'h00);
    chk("rst fe_out", fe_out, 8'h60);
    chk("rst por_done", por_done, 1'b0);
    chk("rst busy", busy, 1'b1);
    chk("rst fe_out_b", fe_out_b, 8'h60);
    #1 reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      at_edge(vt[i].e - 1);
      ctrl    = vt[i].ctrl;
      suspend = vt[i].sus;
      expect_at(vt[i].e, vt[i].rel, vt[i].por, vt[i].busy);
    end

    // Reset mid-GAP: release ch4 at edge 86, reset sampled at edge 87.
    at_edge(85);
    ctrl = 8'h00;
    expect_at(86, 8'h1F, 1, 1);
    at_edge(86);
    reset = 1'b1;
    expect_at(0, 8'h00, 0, 1);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    expect_at(9, 8'h00, 0, 1);
    expect_at(10, 8'h00, 1, 1);
    expect_at(11, 8'h01, 1, 1);
    at_edge(11);
    chk("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Zero-stagger instance: back-to-back releases and suspend straight to IDLE.
  initial begin
    logic [7:0] v;
    @(negedge reset);
    at_edge(10);
    chk("b por_done", por_done_b, 1'b1);
    chk("b e10 released", released_b, 8'h00);
    chk("b e10 busy", busy_b, 1'b0);
    ctrl_b = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      at_edge(10 + k);
      v = 8'((1 << k) - 1);
      chk($sformatf("b e%0d released", 10 + k), released_b, v);
      chk($sformatf("b e%0d fe_out", 10 + k), fe_out_b, v ^ 8'h60);
      chk($sformatf("b e%0d busy", 10 + k), busy_b, (k < 8) ? 1'b1 : 1'b0);
    end
    suspend_b = 1'b1;
    at_edge(19);
    chk("b susp released", released_b, 8'h00);
    chk("b susp fe_out", fe_out_b, 8'h60);
    chk("b susp busy", busy_b, 1'b1);
    suspend_b = 1'b0;
    at_edge(20);
    chk("b idle released", released_b, 8'h00);
    chk("b idle busy", busy_b, 1'b1);
    at_edge(21);
    chk("b rerelease", released_b, 8'h01);
  end

endmodule

// File: doc/fe_power_seq.md
# fe_power_seq

Parametrised front-end power/reset sequencer, the successor to the fixed `reset_ctrl`/`suspend` pin mapping in the Joker TV top level. It holds all N_CH front-end enables (tuner i2c gate, CI power, antenna 5 V, demod/tuner resets) in their safe levels through a power-on delay. It then releases channels one at a time with a programmable stagger, re-asserts immediately on request, and performs a full safe-state/re-sequence cycle around USB suspend. It sits between `joker_control` (which drives `ctrl`) and the board pins.

## Interface
- N_CH, 8: number of controlled channels (1..32).
- SAFE_VAL, 8'h60: per-channel pin level while held/suspended (bit i for channel i); released level is ~SAFE_VAL[i].
- CLK_PER_US, 50: clk cycles per 1 µs tick (≥1).
- POR_US, 1000000: power-on hold time in µs (≥1).
- STAGGER_US, 1000: minimum gap between consecutive channel releases, and settle time after suspend exit, in µs (0 allowed).
- CNT_W, 32: width of µs wait counter; must hold max(POR_US, STAGGER_US).

- clk  in  1  system clock (usb_ulpi_clk domain).
- reset  in  1  synchronous, active-high.
- suspend  in  1  USB suspend, synchronous to clk.
- ctrl  in  N_CH  requested state per channel; 1 = held (disabled), 0 = released (enabled).
- fe_out  out  N_CH  registered pin levels.
- released  out  N_CH  status: 1 = channel currently released.
- por_done  out  1  high once the power-on hold has expired; stays high until reset.
- busy  out  1  high when state ≠ IDLE or any channel is pending release.

## Operation
- pending = ~ctrl & ~released; assert_req = ctrl & released.
- Prescaler: counts 0..CLK_PER_US-1, emits 1-cycle tick on wrap; cleared to 0 on reset and on every state entry of POR/GAP.
- Wait counter (CNT_W bits): loaded on POR/GAP entry, decremented on tick; expiry = tick while counter == 1. GAP with STAGGER_US = 0 is never entered.
- States:
  - POR: released = 0. Load POR_US. On expiry → IDLE, set por_done.
  - IDLE: if suspend → SUSP. Else if pending ≠ 0: set released bit of lowest-index pending channel, then → GAP (load STAGGER_US), or stay IDLE if STAGGER_US = 0.
  - GAP: if suspend → SUSP. On expiry → IDLE.
  - SUSP: released = 0. When suspend falls → GAP (settle), or → IDLE if STAGGER_US = 0.
- Assertion has priority and is immediate in every state: released &= ~ctrl each cycle, without waiting for or restarting the GAP timer.
- A release in IDLE and an assertion of a different channel in the same cycle both take effect.
- fe_out[i] <= released_next[i] ? ~SAFE_VAL[i] : SAFE_VAL[i], so fe_out tracks released in the same cycle.
- Only one channel is released per IDLE visit. Order is strictly ascending index among the channels pending at that cycle.

## Timing
- Reset (any state, mid-GAP included): next edge gives state = POR, fe_out = SAFE_VAL, released = 0, por_done = 0, busy = 1, prescaler = 0, counter = POR_US.
- por_done and the IDLE entry happen at the edge CLK_PER_US·POR_US, counting the first edge with reset = 0 as edge 1.
- Release latency: a channel pending in IDLE is released at the next edge.
- Consecutive releases are spaced exactly CLK_PER_US·STAGGER_US + 1 edges apart: the GAP wait plus 1 IDLE cycle.
- Assertion latency: ctrl[i] rising is reflected in fe_out[i]/released[i] at the next edge.
- Suspend latency: 1 edge to SUSP, all fe_out = SAFE_VAL. After suspend falls, the first release is at 1 + CLK_PER_US·STAGGER_US + 1 edges.
- Suspend and pending release in the same IDLE cycle: suspend wins and nothing is released.

## Test plan
- POR: CLK_PER_US=2, POR_US=5, STAGGER_US=3, N_CH=8, SAFE_VAL=8'h60, ctrl=8'hFF.
  - Release reset → por_done rises at edge 10.
  - fe_out = 8'h60 throughout, busy falls at edge 10.
- Stagger: same params, ctrl=8'h00 before POR expiry.
  - released goes 01, 03, 07 … FF at edges 11, 18, 25 … 60.
  - fe_out = released ^ 8'h60.
- Immediate assert: during GAP after channel 2 is released, set ctrl[1]=1.
  - released[1] clears at the next edge.
  - The GAP timer is unaffected, and channel 3 is released on schedule.
- Suspend: with released = 8'h0F, pulse suspend for 4 cycles.
  - fe_out = 8'h60 one edge after suspend.
  - After suspend falls: GAP of 6 cycles, then channels 0..3 re-released at 7-edge spacing.
- Reset mid-GAP: assert reset for 1 cycle.
  - Next edge gives released = 0, por_done = 0.
  - A full 10-edge POR elapses before any release.
- STAGGER_US=0: ctrl=8'h00 after POR → channels 0..7 released on 8 consecutive edges.
